// File: rtl/dot_product_feeder_if.sv
// -----------------------------------------------------------------------------
// dot_product_feeder_if
// Bundles every signal between the feeder, its element source, the DotProduct
// instance and the result consumer.
//   slave  : the feeder's view (dot_product_feeder uses this modport)
//   master : the environment's view (element source, DotProduct, consumer)
// Signals
//   in_valid/in_ready/in_a/in_b/in_last : serial (A,B) element stream
//   a_vec/b_vec                         : parallel operand lanes to DotProduct
//   dp_start/dp_value                   : DotProduct start pulse / value
//   res_valid/res_ready/res_data        : captured result port
//   busy                                : feeder is not accepting elements
//   dbg_state                           : current feeder FSM state
// -----------------------------------------------------------------------------
interface dot_product_feeder_if #(
   parameter int N_ELEM = 10,
   parameter int A_W    = 19,
   parameter int B_W    = 10,
   parameter int R_W    = 26
);
   logic                    in_valid;
   logic                    in_ready;
   logic [A_W-1:0]          in_a;
   logic [B_W-1:0]          in_b;
   logic                    in_last;
   logic [N_ELEM*A_W-1:0]   a_vec;
   logic [N_ELEM*B_W-1:0]   b_vec;
   logic                    dp_start;
   logic [R_W-1:0]          dp_value;
   logic                    res_valid;
   logic                    res_ready;
   logic [R_W-1:0]          res_data;
   logic                    busy;
   logic [1:0]              dbg_state;

   modport slave (
      input  in_valid, in_a, in_b, in_last, dp_value, res_ready,
      output in_ready, a_vec, b_vec, dp_start, res_valid, res_data, busy, dbg_state
   );

   modport master (
      output in_valid, in_a, in_b, in_last, dp_value, res_ready,
      input  in_ready, a_vec, b_vec, dp_start, res_valid, res_data, busy, dbg_state
   );
endinterface

// File: rtl/dot_product_feeder.sv
// -----------------------------------------------------------------------------
// dot_product_feeder
// Collects (A,B) element pairs serially, presents them as parallel operand
// lanes to one DotProduct instance, holds them stable while DotProduct works,
// then captures its value and offers it on a result port.
// Ports
//   clk          : rising-edge clock
//   GlobalReset  : asynchronous, active-high reset
//   bus          : dot_product_feeder_if.slave (element stream, operand lanes,
//                  DotProduct start/value, result port, busy, dbg_state)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The feeder raises in_ready only in LOAD; res_valid stays high and
// res_data stays constant until the consumer's res_ready completes a transfer.
// res_ready with res_valid low and in_valid with in_ready low have no effect.
// -----------------------------------------------------------------------------
module dot_product_feeder #(
   parameter int N_ELEM     = 10,
   parameter int A_W        = 19,
   parameter int B_W        = 10,
   parameter int R_W        = 26,
   parameter int DP_LATENCY = 4
) (
   input logic                 clk,
   input logic                 GlobalReset,
   dot_product_feeder_if.slave bus
);

   localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                       state;
   logic [IDX_W-1:0]             idx;
   logic [LAT_W-1:0]             lat_cnt;
   logic [N_ELEM-1:0][A_W-1:0]   a_lanes;
   logic [N_ELEM-1:0][B_W-1:0]   b_lanes;
   logic [R_W-1:0]               res_data_r;
   logic                         in_ready_r;
   logic                         dp_start_r;
   logic                         res_valid_r;
   logic                         busy_r;

   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         state       <= LOAD;
         idx         <= '0;
         lat_cnt     <= '0;
         a_lanes     <= '0;
         b_lanes     <= '0;
         res_data_r  <= '0;
         in_ready_r  <= 1'b1;
         dp_start_r  <= 1'b0;
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         dp_start_r <= 1'b0;
         case (state)
            LOAD: begin
               // in_ready is always 1 here, so in_valid alone marks an accept.
               if (bus.in_valid) begin
                  a_lanes[idx] <= bus.in_a;
                  b_lanes[idx] <= bus.in_b;
                  if (bus.in_last || (idx == IDX_W'(N_ELEM - 1))) begin
                     // Short vector: clear the lanes above the last element so
                     // stale operands from the previous vector cannot add in.
                     for (int k = 0; k < N_ELEM; k++) begin
                        if (k > int'(idx)) begin
                           a_lanes[k] <= '0;
                           b_lanes[k] <= '0;
                        end
                     end
                     idx        <= '0;
                     state      <= START;
                     dp_start_r <= 1'b1;
                     in_ready_r <= 1'b0;
                     busy_r     <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            START: begin
               lat_cnt <= LAT_W'(DP_LATENCY - 1);
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  res_data_r  <= bus.dp_value;
                  res_valid_r <= 1'b1;
                  state       <= HOLD;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            HOLD: begin
               if (bus.res_ready) begin
                  res_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state       <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.a_vec     = a_lanes;
   assign bus.b_vec     = b_lanes;
   assign bus.dp_start  = dp_start_r;
   assign bus.res_valid = res_valid_r;
   assign bus.res_data  = res_data_r;
   assign bus.busy      = busy_r;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_dot_product_feeder.sv
// -----------------------------------------------------------------------------
// tb_dot_product_feeder
// Bench for dot_product_feeder with a DotProduct stub (latency DP_LATENCY,
// value = sum of the b lanes). A cycle-level reference model at the falling
// edge predicts in_ready/busy/dp_start/res_valid/res_data and the operand
// lanes from the accepted elements; a table of vectors and a few hand-written
// sequences cover the multi-cycle corner cases; random vectors follow.
// -----------------------------------------------------------------------------
module tb_dot_product_feeder;
   localparam int N_ELEM     = 10;
   localparam int A_W        = 19;
   localparam int B_W        = 10;
   localparam int R_W        = 26;
   localparam int DP_LATENCY = 4;

   typedef logic [A_W-1:0] a_arr_t [N_ELEM];
   typedef logic [B_W-1:0] b_arr_t [N_ELEM];

   typedef struct {
      int             len;
      bit             use_last;
      int             bp;
      bit             bubbles;
      logic [A_W-1:0] a;
      b_arr_t         b;
      logic [R_W-1:0] exp_sum;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   initial forever #5 clk = ~clk;

   dot_product_feeder_if #(.N_ELEM(N_ELEM), .A_W(A_W), .B_W(B_W), .R_W(R_W)) bus ();

   dot_product_feeder #(
      .N_ELEM(N_ELEM), .A_W(A_W), .B_W(B_W), .R_W(R_W), .DP_LATENCY(DP_LATENCY)
   ) dut (
      .clk         (clk),
      .GlobalReset (rst),
      .bus         (bus)
   );

   // ---------------- DotProduct stub ----------------
   function automatic logic [R_W-1:0] lane_sum(input logic [N_ELEM*B_W-1:0] v);
      logic [R_W-1:0] s;
      s = '0;
      for (int k = 0; k < N_ELEM; k++) s = s + R_W'(v[k*B_W +: B_W]);
      return s;
   endfunction

   logic [R_W-1:0] pipe [DP_LATENCY];
   always @(posedge clk) begin
      pipe[0] <= lane_sum(bus.b_vec);
      for (int i = 1; i < DP_LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.dp_value = pipe[DP_LATENCY-1];

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model, evaluated on the falling edge: sees the inputs and
   // outputs that the next rising edge will act on.
   bit                    m_loading = 1'b1;
   bit                    m_pending = 1'b0;
   int                    cyc       = 0;
   int                    due       = -1;
   int                    start_due = -1;
   logic [R_W-1:0]        exp_q[$];
   logic [A_W-1:0]        cur_a[$];
   logic [B_W-1:0]        cur_b[$];
   logic [N_ELEM*A_W-1:0] exp_a_vec = '0;
   logic [N_ELEM*B_W-1:0] exp_b_vec = '0;
   int                    acc_cyc[$];

   always @(negedge clk) begin
      if (rst) begin
         m_loading = 1'b1;
         m_pending = 1'b0;
         due       = -1;
         start_due = -1;
         exp_q.delete();
         cur_a.delete();
         cur_b.delete();
         exp_a_vec = '0;
         exp_b_vec = '0;
      end else begin
         bit             rv_exp;
         logic [R_W-1:0] sum;
         rv_exp = m_pending && (cyc >= due);
         chk("in_ready", bus.in_ready, m_loading);
         chk("busy", bus.busy, !m_loading);
         chk("dp_start", bus.dp_start, cyc == start_due);
         chk("res_valid", bus.res_valid, rv_exp);
         if (rv_exp) chk("res_data", bus.res_data, exp_q[0]);
         if (!m_loading) begin
            chk("a_vec_hold", bus.a_vec, exp_a_vec);
            chk("b_vec_hold", bus.b_vec, exp_b_vec);
         end
         if (rv_exp && bus.res_ready) begin
            void'(exp_q.pop_front());
            m_pending = 1'b0;
            m_loading = 1'b1;
         end else if (m_loading && bus.in_valid) begin
            acc_cyc.push_back(cyc);
            cur_a.push_back(bus.in_a);
            cur_b.push_back(bus.in_b);
            if (bus.in_last || cur_a.size() == N_ELEM) begin
               exp_a_vec = '0;
               exp_b_vec = '0;
               sum = '0;
               foreach (cur_a[i]) begin
                  exp_a_vec[i*A_W +: A_W] = cur_a[i];
                  exp_b_vec[i*B_W +: B_W] = cur_b[i];
                  sum = sum + R_W'(cur_b[i]);
               end
               exp_q.push_back(sum);
               cur_a.delete();
               cur_b.delete();
               m_pending = 1'b1;
               m_loading = 1'b0;
               start_due = cyc + 1;
               due       = cyc + DP_LATENCY + 2;
            end
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input bit last);
      int w = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_last  = last;
      while (!bus.in_ready && w < 100) begin
         tick();
         w++;
      end
      chk("push_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_result(input int bp, input bit noise, output logic [R_W-1:0] got);
      int w = 0;
      bus.res_ready = (bp == 0);
      while (!bus.res_valid && w < 100) begin
         if (noise) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_a     = A_W'($urandom);
            bus.in_b     = B_W'($urandom);
            bus.in_last  = 1'($urandom_range(0, 1));
         end
         tick();
         w++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("result_arrives", bus.res_valid, 1);
      repeat (bp) tick();
      bus.res_ready = 1'b1;
      got = bus.res_data;
      tick();
      bus.res_ready = 1'b0;
   endtask

   task automatic run_vec(input a_arr_t a, input b_arr_t b, input int len, input bit use_last,
                          input bit bubbles, input int bp, input bit noise,
                          output logic [R_W-1:0] got);
      for (int i = 0; i < len; i++) begin
         if (bubbles) begin
            // idle cycle with a stray in_last that must be ignored
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b1;
            bus.in_b     = '1;
            tick();
         end
         push(a[i], b[i], (i == len - 1) && (use_last || len < N_ELEM));
      end
      wait_result(bp, noise, got);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_res_valid"}, bus.res_valid, 0);
      chk({tag, "_dp_start"}, bus.dp_start, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_res_data"}, bus.res_data, 0);
      chk({tag, "_a_vec"}, bus.a_vec, 0);
      chk({tag, "_b_vec"}, bus.b_vec, 0);
   endtask

   // Reset asserted between clock edges; outputs are checked before any edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs(tag);
      @(negedge clk);
      #2 rst = 1'b0;
      bus.res_ready = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      tick();
   endtask

   function automatic vec_t mk(input int len, input bit ul, input int bp, input bit bub,
                               input logic [A_W-1:0] a, input int base, input int step,
                               input logic [R_W-1:0] exp_sum);
      vec_t v;
      v.len = len; v.use_last = ul; v.bp = bp; v.bubbles = bub; v.a = a; v.exp_sum = exp_sum;
      for (int k = 0; k < N_ELEM; k++) v.b[k] = B_W'(base + step * k);
      return v;
   endfunction

   // ---------------- test sequence ----------------
   vec_t           tbl [7];
   a_arr_t         av;
   b_arr_t         bv;
   logic [R_W-1:0] got;
   logic [R_W-1:0] rsum;
   bit             rv_seen;
   int             w;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.res_ready = 1'b0;

      // power-up reset, checked before the first clock edge
      #1 rst = 1'b1;
      #1 check_reset_outputs("por");
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      tick();

      tbl[0] = mk(10, 0, 0, 0, 19'h20000, 0,    1, 45);    // full vector, no in_last
      tbl[1] = mk(3,  1, 0, 0, 19'h12345, 7,    1, 24);    // short vector 7,8,9
      tbl[2] = mk(10, 0, 6, 0, 19'h7FFFF, 0,    1, 45);    // result backpressure
      tbl[3] = mk(10, 0, 0, 1, 19'h00001, 0,    1, 45);    // bubbles on in_valid
      tbl[4] = mk(10, 1, 0, 0, 19'h40000, 1023, 0, 10230); // in_last on the 10th
      tbl[5] = mk(1,  1, 2, 0, 19'h3FFFF, 5,    0, 5);     // single element
      tbl[6] = mk(9,  1, 1, 1, 19'h00100, 100,  0, 900);   // one lane short

      foreach (tbl[i]) begin
         for (int k = 0; k < N_ELEM; k++) av[k] = tbl[i].a;
         run_vec(av, tbl[i].b, tbl[i].len, tbl[i].use_last, tbl[i].bubbles, tbl[i].bp, 1'b0, got);
         chk($sformatf("table%0d_res", i), got, tbl[i].exp_sum);
         if (i == 0) begin
            for (int k = 0; k < N_ELEM; k++) begin
               chk($sformatf("full_a_lane%0d", k), bus.a_vec[k*A_W +: A_W], 19'h20000);
               chk($sformatf("full_b_lane%0d", k), bus.b_vec[k*B_W +: B_W], k);
            end
         end
         if (i == 1) begin
            for (int k = 0; k < N_ELEM; k++) begin
               chk($sformatf("short_a_lane%0d", k), bus.a_vec[k*A_W +: A_W], (k < 3) ? 19'h12345 : 19'h0);
               chk($sformatf("short_b_lane%0d", k), bus.b_vec[k*B_W +: B_W], (k < 3) ? 7 + k : 0);
            end
         end
      end

      // back-to-back full vectors with res_ready held: B=k then B=2k
      acc_cyc.delete();
      for (int k = 0; k < N_ELEM; k++) begin av[k] = A_W'(k); bv[k] = B_W'(k); end
      run_vec(av, bv, N_ELEM, 1'b0, 1'b0, 0, 1'b0, got);
      chk("b2b_first", got, 45);
      for (int k = 0; k < N_ELEM; k++) bv[k] = B_W'(2 * k);
      run_vec(av, bv, N_ELEM, 1'b0, 1'b0, 0, 1'b0, got);
      chk("b2b_second", got, 90);
      chk("throughput", acc_cyc[N_ELEM] - acc_cyc[0], N_ELEM + DP_LATENCY + 2);

      // reset two cycles after dp_start: the result must never appear
      for (int k = 0; k < N_ELEM; k++) push(19'h00007, 10'd1, 1'b0);
      chk("abort_dp_start", bus.dp_start, 1);
      tick();
      tick();
      async_reset("wait_rst");
      rv_seen = 1'b0;
      repeat (12) begin
         tick();
         if (bus.res_valid) rv_seen = 1'b1;
      end
      chk("abort_no_result", rv_seen, 0);
      for (int k = 0; k < N_ELEM; k++) bv[k] = 10'd1;
      run_vec(av, bv, N_ELEM, 1'b0, 1'b0, 0, 1'b0, got);
      chk("after_abort_res", got, 10);

      // reset while a result is waiting for the consumer
      push(19'h00002, 10'd3, 1'b0);
      push(19'h00004, 10'd3, 1'b1);
      bus.res_ready = 1'b0;
      w = 0;
      while (!bus.res_valid && w < 50) begin
         tick();
         w++;
      end
      chk("hold_reached", bus.res_valid, 1);
      async_reset("hold_rst");

      // random vectors against the model
      repeat (40) begin
         int len;
         len  = $urandom_range(1, N_ELEM);
         rsum = '0;
         for (int k = 0; k < N_ELEM; k++) begin
            av[k] = A_W'($urandom);
            bv[k] = B_W'($urandom);
            if (k < len) rsum = rsum + R_W'(bv[k]);
         end
         run_vec(av, bv, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'b1, got);
         chk("rand_res", got, rsum);
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
